// File: rtl/exec_pkg.sv
// Shared types for the execute stage: ALU opcodes, branch conditions,
// M-extension op codes, mul/div FSM states and forwarding selects.
package exec_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_op_e;

   localparam logic [2:0] BR_EQ  = 3'b000;
   localparam logic [2:0] BR_NE  = 3'b001;
   localparam logic [2:0] BR_LT  = 3'b100;
   localparam logic [2:0] BR_GE  = 3'b101;
   localparam logic [2:0] BR_LTU = 3'b110;
   localparam logic [2:0] BR_GEU = 3'b111;

   typedef enum logic [2:0] {
      MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU,
      MD_DIV, MD_DIVU, MD_REM, MD_REMU
   } muldiv_op_e;

   typedef enum logic [1:0] {MD_IDLE, MD_CALC, MD_DONE} md_state_e;

   typedef enum logic [1:0] {FWD_RF, FWD_W, FWD_M, FWD_ZERO} fwd_sel_e;

   function automatic logic opSignedA(muldiv_op_e op);
      return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
             (op == MD_DIV) || (op == MD_REM);
   endfunction

   function automatic logic opSignedB(muldiv_op_e op);
      return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
   endfunction

endpackage

// File: rtl/execute_stage_m_muldiv.sv
// Iterative radix-2 multiply / restoring divide on operand magnitudes,
// with the sign fix-up applied to the final product, quotient or remainder.
module muldiv_iter
   import exec_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush_i,
   input  logic            start_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);
   localparam int CW = $clog2(XLEN);

   md_state_e       state_q, state_d;
   muldiv_op_e      op_q, op_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            negRes_q, negRes_d, negRem_q, negRem_d;
   logic [XLEN-1:0] acc_q, acc_d, lo_q, lo_d, mcand_q, mcand_d;

   logic            signA, signB;
   logic [XLEN:0]   mulSum, divShift, divDiff;

   assign signA    = opSignedA(muldiv_op_e'(op_i)) & a_i[XLEN-1];
   assign signB    = opSignedB(muldiv_op_e'(op_i)) & b_i[XLEN-1];
   assign mulSum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
   assign divShift = {acc_q, lo_q[XLEN-1]};
   assign divDiff  = divShift - {1'b0, mcand_q};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= MD_IDLE;
         op_q     <= MD_MUL;
         cnt_q    <= '0;
         negRes_q <= 1'b0;
         negRem_q <= 1'b0;
         acc_q    <= '0;
         lo_q     <= '0;
         mcand_q  <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         negRes_q <= negRes_d;
         negRem_q <= negRem_d;
         acc_q    <= acc_d;
         lo_q     <= lo_d;
         mcand_q  <= mcand_d;
      end
   end

   // lo_q holds the multiplier (shifted out) or dividend/quotient (shifted through).
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      negRes_d = negRes_q;
      negRem_d = negRem_q;
      acc_d    = acc_q;
      lo_d     = lo_q;
      mcand_d  = mcand_q;
      busy_o   = 1'b0;
      done_o   = 1'b0;
      case (state_q)
         MD_IDLE: begin
            if (start_i && !flush_i) begin
               busy_o   = 1'b1;
               state_d  = MD_CALC;
               op_d     = muldiv_op_e'(op_i);
               cnt_d    = CW'(XLEN - 1);
               negRes_d = (signA ^ signB) & (~op_i[2] | (|b_i));
               negRem_d = signA;
               acc_d    = '0;
               lo_d     = signA ? -a_i : a_i;
               mcand_d  = signB ? -b_i : b_i;
            end
         end
         MD_CALC: begin
            busy_o = 1'b1;
            if (flush_i) begin
               state_d = MD_IDLE;
            end else begin
               if (!op_q[2]) begin
                  acc_d = mulSum[XLEN:1];
                  lo_d  = {mulSum[0], lo_q[XLEN-1:1]};
               end else begin
                  acc_d = divDiff[XLEN] ? divShift[XLEN-1:0] : divDiff[XLEN-1:0];
                  lo_d  = {lo_q[XLEN-2:0], ~divDiff[XLEN]};
               end
               if (cnt_q == '0) state_d = MD_DONE;
               else             cnt_d   = cnt_q - 1'b1;
            end
         end
         MD_DONE: begin
            state_d = MD_IDLE;
            done_o  = !flush_i;
         end
         default: state_d = MD_IDLE;
      endcase
   end

   logic [2*XLEN-1:0] prod, prodFix;
   logic [XLEN-1:0]   quotFix, remFix;

   always_comb begin
      prod     = {acc_q, lo_q};
      prodFix  = negRes_q ? -prod : prod;
      quotFix  = negRes_q ? -lo_q : lo_q;
      remFix   = negRem_q ? -acc_q : acc_q;
      result_o = '0;
      case (op_q)
         MD_MUL:                       result_o = prodFix[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU: result_o = prodFix[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:              result_o = quotFix;
         default:                      result_o = remFix;
      endcase
   end

endmodule

// File: rtl/execute_stage_m.sv
// RV32/RV64 execute stage: operand forwarding, ALU, branch/jump resolution
// and an optional iterative M-extension unit that stalls the pipeline.
module execute_stage_m
   import exec_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter bit MULDIV_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            FlushE,
   input  logic [1:0]      ForwardAE,
   input  logic [1:0]      ForwardBE,
   input  logic            ALUSrcE,
   input  logic [3:0]      ALUControlE,
   input  logic            BranchE,
   input  logic            JumpE,
   input  logic            JalrE,
   input  logic [2:0]      Funct3E,
   input  logic            MulDivE,
   input  logic [XLEN-1:0] PCE,
   input  logic [XLEN-1:0] ExtImmE,
   input  logic [XLEN-1:0] RD1E,
   input  logic [XLEN-1:0] RD2E,
   input  logic [XLEN-1:0] ALUResultM,
   input  logic [XLEN-1:0] ResultW,
   output logic [XLEN-1:0] ALUResultE,
   output logic [XLEN-1:0] WriteDataE,
   output logic [XLEN-1:0] PCTargetE,
   output logic            PCSrcE,
   output logic            StallMDE
);
   localparam int SHW = $clog2(XLEN);

   logic [XLEN-1:0] srcAE, srcBE, aluResult, mdResult, jalrSum;
   logic            zero, ltS, ltU, taken, mdBusy, mdDone;

   always_comb begin
      srcAE      = '0;
      WriteDataE = '0;
      case (fwd_sel_e'(ForwardAE))
         FWD_RF:  srcAE = RD1E;
         FWD_W:   srcAE = ResultW;
         FWD_M:   srcAE = ALUResultM;
         default: srcAE = '0;
      endcase
      case (fwd_sel_e'(ForwardBE))
         FWD_RF:  WriteDataE = RD2E;
         FWD_W:   WriteDataE = ResultW;
         FWD_M:   WriteDataE = ALUResultM;
         default: WriteDataE = '0;
      endcase
   end

   assign srcBE = ALUSrcE ? ExtImmE : WriteDataE;
   assign zero  = (srcAE == srcBE);
   assign ltS   = $signed(srcAE) < $signed(srcBE);
   assign ltU   = srcAE < srcBE;

   always_comb begin
      aluResult = '0;
      case (alu_op_e'(ALUControlE))
         ALU_ADD:  aluResult = srcAE + srcBE;
         ALU_SUB:  aluResult = srcAE - srcBE;
         ALU_AND:  aluResult = srcAE & srcBE;
         ALU_OR:   aluResult = srcAE | srcBE;
         ALU_XOR:  aluResult = srcAE ^ srcBE;
         ALU_SLL:  aluResult = srcAE << srcBE[SHW-1:0];
         ALU_SRL:  aluResult = srcAE >> srcBE[SHW-1:0];
         ALU_SRA:  aluResult = $signed(srcAE) >>> srcBE[SHW-1:0];
         ALU_SLT:  aluResult = {{(XLEN-1){1'b0}}, ltS};
         ALU_SLTU: aluResult = {{(XLEN-1){1'b0}}, ltU};
         default:  aluResult = '0;
      endcase
   end

   always_comb begin
      taken = 1'b0;
      case (Funct3E)
         BR_EQ:   taken = zero;
         BR_NE:   taken = !zero;
         BR_LT:   taken = ltS;
         BR_GE:   taken = !ltS;
         BR_LTU:  taken = ltU;
         BR_GEU:  taken = !ltU;
         default: taken = 1'b0;
      endcase
   end

   assign jalrSum   = srcAE + ExtImmE;
   assign PCTargetE = JalrE ? (jalrSum & {{(XLEN-1){1'b1}}, 1'b0}) : (PCE + ExtImmE);
   // A redirect must not fire while the stalled mul/div still occupies E.
   assign PCSrcE    = ((BranchE & taken) | JumpE) & ~mdBusy;
   assign StallMDE  = mdBusy;
   assign ALUResultE = mdDone ? mdResult : aluResult;

   if (MULDIV_EN) begin : g_muldiv
      muldiv_iter #(.XLEN(XLEN)) u_muldiv (
         .clk      (clk),
         .rst_n    (rst_n),
         .flush_i  (FlushE),
         .start_i  (MulDivE),
         .op_i     (Funct3E),
         .a_i      (srcAE),
         .b_i      (WriteDataE),
         .busy_o   (mdBusy),
         .done_o   (mdDone),
         .result_o (mdResult)
      );
   end else begin : g_no_muldiv
      assign mdBusy   = 1'b0;
      assign mdDone   = 1'b0;
      assign mdResult = '0;
   end

endmodule

// File: tb/tb_execute_stage_m.sv
// Scoreboard bench for execute_stage_m at XLEN=32: stimulus pushes expected
// values, a negedge monitor pops and compares them as the DUT presents them.
module tb_execute_stage_m;
   import exec_pkg::*;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst_n, FlushE, ALUSrcE, BranchE, JumpE, JalrE, MulDivE;
   logic [1:0]      ForwardAE, ForwardBE;
   logic [3:0]      ALUControlE;
   logic [2:0]      Funct3E;
   logic [XLEN-1:0] PCE, ExtImmE, RD1E, RD2E, ALUResultM, ResultW;
   logic [XLEN-1:0] ALUResultE, WriteDataE, PCTargetE;
   logic            PCSrcE, StallMDE;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] exp;
   } comb_t;

   typedef struct {
      string       name;
      bit          abort;
      int          expStall;
      logic [31:0] exp;
   } md_t;

   comb_t combQ[$];
   md_t   mdQ[$];

   execute_stage_m #(.XLEN(XLEN), .MULDIV_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .FlushE(FlushE),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ALUSrcE(ALUSrcE),
      .ALUControlE(ALUControlE), .BranchE(BranchE), .JumpE(JumpE), .JalrE(JalrE),
      .Funct3E(Funct3E), .MulDivE(MulDivE), .PCE(PCE), .ExtImmE(ExtImmE),
      .RD1E(RD1E), .RD2E(RD2E), .ALUResultM(ALUResultM), .ResultW(ResultW),
      .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .PCTargetE(PCTargetE),
      .PCSrcE(PCSrcE), .StallMDE(StallMDE)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] getSig(input int sel);
      case (sel)
         0:       return ALUResultE;
         1:       return {31'b0, PCSrcE};
         2:       return PCTargetE;
         3:       return {31'b0, StallMDE};
         default: return WriteDataE;
      endcase
   endfunction

   task automatic expectComb(input string name, input int sel, input logic [31:0] exp);
      comb_t c;
      c.name = name; c.sel = sel; c.exp = exp;
      combQ.push_back(c);
   endtask

   task automatic expectMd(input string name, input bit abort, input int stallLen, input logic [31:0] exp);
      md_t m;
      m.name = name; m.abort = abort; m.expStall = stallLen; m.exp = exp;
      mdQ.push_back(m);
   endtask

   // ---------------- reference models ----------------
   function automatic logic [31:0] refAlu(input int op, input logic [31:0] a, input logic [31:0] b);
      int sh;
      sh = int'(b % 32);
      case (op)
         0:       return a + b;
         1:       return a - b;
         2:       return a & b;
         3:       return a | b;
         4:       return a ^ b;
         5:       return a << sh;
         6:       return a >> sh;
         7:       return $signed(a) >>> sh;
         8:       return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         9:       return (a < b) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   function automatic bit refTaken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'b000:  return a == b;
         3'b001:  return a != b;
         3'b100:  return $signed(a) < $signed(b);
         3'b101:  return $signed(a) >= $signed(b);
         3'b110:  return a < b;
         3'b111:  return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] refMd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ub, p, q;
      longint unsigned up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ub = longint'({32'b0, b});
      case (op)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            q = sa / sb;
            return q[31:0];
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            q = sa % sb;
            return q[31:0];
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // ---------------- monitor ----------------
   int stallRun = 0;

   always @(negedge clk) begin
      while (combQ.size() > 0) begin
         comb_t c;
         c = combQ.pop_front();
         checkOutput(c.name, getSig(c.sel), c.exp);
      end
      if (StallMDE) begin
         stallRun++;
      end else if (stallRun > 0) begin
         if (mdQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected stall end: got %0d stall cycles expected none", stallRun);
         end else begin
            md_t m;
            m = mdQ.pop_front();
            checkOutput({m.name, " stall"}, stallRun, m.expStall);
            if (!m.abort) checkOutput(m.name, ALUResultE, m.exp);
         end
         stallRun = 0;
      end
   end

   // ---------------- stimulus ----------------
   task automatic applyStimulus(input string name, input logic [1:0] fa, input logic [1:0] fb,
                                input logic srcSel, input int op, input logic br, input logic jmp,
                                input logic jalr, input logic [2:0] f3,
                                input logic [31:0] rd1, input logic [31:0] rd2,
                                input logic [31:0] m, input logic [31:0] w,
                                input logic [31:0] imm, input logic [31:0] pc);
      logic [31:0] a, wd, b, tgt;
      @(posedge clk); #1;
      FlushE = 1'b0; MulDivE = 1'b0;
      ForwardAE = fa; ForwardBE = fb; ALUSrcE = srcSel; ALUControlE = op[3:0];
      BranchE = br; JumpE = jmp; JalrE = jalr; Funct3E = f3;
      RD1E = rd1; RD2E = rd2; ALUResultM = m; ResultW = w; ExtImmE = imm; PCE = pc;
      a  = (fa == 2'd0) ? rd1 : (fa == 2'd1) ? w : (fa == 2'd2) ? m : 32'd0;
      wd = (fb == 2'd0) ? rd2 : (fb == 2'd1) ? w : (fb == 2'd2) ? m : 32'd0;
      b  = srcSel ? imm : wd;
      tgt = jalr ? ((a + imm) & 32'hFFFF_FFFE) : (pc + imm);
      expectComb({name, " alu"}, 0, refAlu(op, a, b));
      expectComb({name, " wdata"}, 4, wd);
      expectComb({name, " pcsrc"}, 1, {31'b0, (br & refTaken(f3, a, b)) | jmp});
      expectComb({name, " target"}, 2, tgt);
   endtask

   task automatic waitMdFall(input string name);
      bit seen = 1'b0;
      bit done = 1'b0;
      for (int i = 0; i < XLEN + 20 && !done; i++) begin
         @(negedge clk);
         if (StallMDE) seen = 1'b1;
         else if (seen) done = 1'b1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s timeout: stall seen=%0d, expected a completed stall window", name, seen);
      end
   endtask

   // Operands are routed through a randomly chosen forwarding path.
   task automatic driveMd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic jmp);
      int fa, fb;
      fa = $urandom_range(0, 2);
      fb = $urandom_range(0, 2);
      if (fb == fa && fa != 0) fb = 0;
      FlushE = 1'b0; MulDivE = 1'b1; Funct3E = op; ALUSrcE = 1'b0; ALUControlE = 4'd0;
      BranchE = 1'b0; JumpE = jmp; JalrE = 1'b0;
      RD1E = $urandom; RD2E = $urandom; ResultW = $urandom; ALUResultM = $urandom;
      ForwardAE = fa[1:0]; ForwardBE = fb[1:0];
      case (fa)
         0:       RD1E = a;
         1:       ResultW = a;
         default: ALUResultM = a;
      endcase
      case (fb)
         0:       RD2E = b;
         1:       ResultW = b;
         default: ALUResultM = b;
      endcase
   endtask

   task automatic applyMulDiv(input string name, input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp, input logic jmp);
      @(posedge clk); #1;
      driveMd(op, a, b, jmp);
      expectMd(name, 1'b0, XLEN + 1, exp);
      if (jmp) expectComb({name, " pcsrc gated"}, 1, 32'd0);
      waitMdFall(name);
      @(posedge clk); #1;
      MulDivE = 1'b0; JumpE = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got no finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] corner [5];
      logic [31:0] ra, rb;
      logic [2:0]  rop;
      corner[0] = 32'd0; corner[1] = 32'd1; corner[2] = 32'hFFFF_FFFF;
      corner[3] = 32'h8000_0000; corner[4] = 32'h7FFF_FFFF;

      rst_n = 1'b0; FlushE = 1'b0; ForwardAE = 2'd0; ForwardBE = 2'd0; ALUSrcE = 1'b0;
      ALUControlE = 4'd0; BranchE = 1'b0; JumpE = 1'b0; JalrE = 1'b0; Funct3E = 3'd0;
      MulDivE = 1'b0; PCE = '0; ExtImmE = '0; RD1E = '0; RD2E = '0; ALUResultM = '0; ResultW = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      expectComb("reset stall", 3, 32'd0);

      // Forwarding
      applyStimulus("fwd M", 2'd2, 2'd0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 3'd0,
                    32'd5, 32'd0, 32'd9, 32'd7, 32'd3, 32'd0);
      expectComb("fwd M literal", 0, 32'd12);
      applyStimulus("fwd W", 2'd1, 2'd0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 3'd0,
                    32'd5, 32'd0, 32'd9, 32'd7, 32'd3, 32'd0);
      expectComb("fwd W literal", 0, 32'd10);

      // Branch signed vs unsigned, PC-relative target
      applyStimulus("blt", 2'd0, 2'd0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 3'b100,
                    32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'h20, 32'h100);
      expectComb("blt literal", 1, 32'd1);
      expectComb("blt target literal", 2, 32'h120);
      applyStimulus("bltu", 2'd0, 2'd0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 3'b110,
                    32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'h20, 32'h100);
      expectComb("bltu literal", 1, 32'd0);
      applyStimulus("f3 010", 2'd0, 2'd0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 3'b010,
                    32'd4, 32'd4, 32'd0, 32'd0, 32'h20, 32'h100);
      expectComb("f3 010 literal", 1, 32'd0);

      // JALR
      applyStimulus("jalr", 2'd0, 2'd0, 1'b1, 0, 1'b0, 1'b1, 1'b1, 3'd0,
                    32'h1003, 32'd0, 32'd0, 32'd0, 32'd4, 32'h400);
      expectComb("jalr target literal", 2, 32'h1006);
      expectComb("jalr pcsrc literal", 1, 32'd1);

      // Randomized ALU / branch / forwarding
      for (int i = 0; i < 40; i++) begin
         logic [31:0] r1, r2;
         r1 = $urandom;
         r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
         applyStimulus("rand alu", 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), $urandom_range(0, 9),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       3'($urandom_range(0, 7)), r1, r2, $urandom, $urandom, $urandom, $urandom);
      end

      // Directed M-extension cases
      applyMulDiv("mul -3*7", 3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 1'b1);
      applyMulDiv("mulh -3*7", 3'd1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 1'b0);
      applyMulDiv("div 7/0", 3'd4, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b0);
      applyMulDiv("rem 7/0", 3'd6, 32'd7, 32'd0, 32'd7, 1'b0);
      applyMulDiv("div ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
      applyMulDiv("rem ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
      applyMulDiv("div -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
      applyMulDiv("rem -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
      applyMulDiv("div -7/0", 3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1'b0);

      // Flush during the start cycle suppresses the operation
      @(posedge clk); #1;
      driveMd(3'd0, 32'd3, 32'd4, 1'b0);
      FlushE = 1'b1;
      expectComb("start flush stall", 3, 32'd0);
      @(posedge clk); #1;
      FlushE = 1'b0; MulDivE = 1'b0;
      expectComb("start flush after", 3, 32'd0);

      // Flush in the tenth CALC cycle
      @(posedge clk); #1;
      driveMd(3'd0, 32'd5, 32'd9, 1'b0);
      expectMd("flush calc10", 1'b1, 11, 32'd0);
      repeat (10) @(posedge clk);
      #1 FlushE = 1'b1; MulDivE = 1'b0;
      @(posedge clk); #1 FlushE = 1'b0;
      applyMulDiv("mul 6*7", 3'd0, 32'd6, 32'd7, 32'd42, 1'b0);

      // Reset mid-CALC discards the operation
      @(posedge clk); #1;
      driveMd(3'd5, 32'd100, 32'd3, 1'b0);
      expectMd("reset calc5", 1'b1, 6, 32'd0);
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0; MulDivE = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      expectComb("reset mid calc stall", 3, 32'd0);
      applyMulDiv("divu after reset", 3'd5, 32'd100, 32'd3, 32'd33, 1'b0);

      // Randomized M-extension ops against the arithmetic model
      for (int i = 0; i < 24; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
         rb  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
         if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(16, 31);
         applyMulDiv("rand muldiv", rop, ra, rb, refMd(rop, ra, rb), 1'b0);
      end

      repeat (3) @(posedge clk);
      if (mdQ.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL pending mul/div: got %0d unfinished expected 0", mdQ.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
